// File: rtl/music_sequencer.sv
// music_sequencer: beat sequencer for a song ROM with live-key override.
//
// Steps a song ROM through beats 0..255 at a selectable tempo, supports
// play / pause / stop requests (priority stop > play > pause_req), and
// arbitrates the audio tone between a held piano key, the song ROM and
// silence. All outputs are registered.
//
// Build option:
//   SEQ_LOOP_EN  defined   -> after beat 255 wrap to beat 0 and keep playing
//                undefined -> after beat 255 enter DONE and go quiet
//
// Parameters:
//   BEAT_DIV  clk cycles per quarter-beat at tempo 0 (minimum 8)
//   SILENCE   tone code driven when nothing is playing
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   play       start / resume request (pulse)
//   pause_req  pause request (pulse)
//   stop       stop request (pulse)
//   tempo      speed select, beat length = BEAT_DIV >> tempo
//   key_valid  a piano key is held
//   key_tone   tone of the held key
//   song_tone  tone returned by the song ROM for ibeatNum
//   ibeatNum   beat index to the song ROM
//   en_b       song ROM enable (PLAY or PAUSE)
//   pause      song ROM pause (PAUSE only)
//   tone       arbitrated tone, one-cycle latency
//   busy       high in PLAY or PAUSE
//   done       one-cycle pulse when beat 255 completes

module music_sequencer #(
  parameter int unsigned BEAT_DIV = 12500000,
  parameter logic [31:0] SILENCE  = 32'd20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        pause_req,
  input  logic        stop,
  input  logic [1:0]  tempo,
  input  logic        key_valid,
  input  logic [31:0] key_tone,
  input  logic [31:0] song_tone,
  output logic [7:0]  ibeatNum,
  output logic        en_b,
  output logic        pause,
  output logic [31:0] tone,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TICK_W = $clog2(BEAT_DIV + 1);
  localparam int unsigned BEAT_W = 8;
  localparam int unsigned TONE_W = 32;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(255);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Registered state and datapath
  state_t              r_state;
  logic [TICK_W-1:0]   r_tick;
  logic [TICK_W-1:0]   r_div;
  logic [BEAT_W-1:0]   r_beat;
  logic [TONE_W-1:0]   r_tone;
  logic                r_en_b;
  logic                r_pause;
  logic                r_busy;
  logic                r_done;

  // Next-state values
  state_t              w_state_nxt;
  logic [TICK_W-1:0]   w_tick_nxt;
  logic [TICK_W-1:0]   w_div_nxt;
  logic [BEAT_W-1:0]   w_beat_nxt;
  logic [TONE_W-1:0]   w_tone_nxt;
  logic                w_en_b_nxt;
  logic                w_pause_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  // Beat length: tempo is only taken at the start of a beat (tick 0),
  // otherwise the length latched at that start is kept.
  logic [TICK_W-1:0]   w_div_in;
  logic [TICK_W-1:0]   w_div_cur;
  logic                w_term;

  assign w_div_in  = TICK_W'(BEAT_DIV >> tempo);
  assign w_div_cur = (r_tick == '0) ? w_div_in : r_div;
  assign w_term    = (r_tick == (w_div_cur - TICK_W'(1)));

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_div   <= TICK_W'(BEAT_DIV);
      r_beat  <= '0;
      r_tone  <= SILENCE;
      r_en_b  <= 1'b0;
      r_pause <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_div   <= w_div_nxt;
      r_beat  <= w_beat_nxt;
      r_tone  <= w_tone_nxt;
      r_en_b  <= w_en_b_nxt;
      r_pause <= w_pause_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state, beat counting and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_div_nxt   = r_div;
    w_beat_nxt  = r_beat;
    w_done_nxt  = 1'b0;
    w_tone_nxt  = SILENCE;
    w_en_b_nxt  = 1'b0;
    w_pause_nxt = 1'b0;
    w_busy_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (play) w_state_nxt = S_PLAY;
      end

      S_PLAY: begin
        // play in the same cycle outranks pause_req and keeps playing
        if (pause_req && !play) begin
          w_state_nxt = S_PAUSE;
        end else begin
          w_div_nxt = w_div_cur;
          if (w_term) begin
            w_tick_nxt = '0;
            w_beat_nxt = r_beat + BEAT_W'(1);
            if (r_beat == LAST_BEAT) begin
              w_done_nxt = 1'b1;
`ifndef SEQ_LOOP_EN
              w_state_nxt = S_DONE;
`endif
            end
          end else begin
            w_tick_nxt = r_tick + TICK_W'(1);
          end
        end
      end

      S_PAUSE: begin
        // tick and beat are held so resuming continues mid-beat
        if (play) w_state_nxt = S_PLAY;
      end

      S_DONE: begin
        // beat index is already 0 here, so play restarts the song
        if (play) w_state_nxt = S_PLAY;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // stop outranks everything and rewinds in the same edge
    if (stop) begin
      w_state_nxt = S_IDLE;
      w_tick_nxt  = '0;
      w_beat_nxt  = '0;
      w_done_nxt  = 1'b0;
    end

    // Outputs follow the state being entered so they line up with it
    w_en_b_nxt  = (w_state_nxt == S_PLAY) || (w_state_nxt == S_PAUSE);
    w_busy_nxt  = w_en_b_nxt;
    w_pause_nxt = (w_state_nxt == S_PAUSE);

    if (key_valid) begin
      w_tone_nxt = key_tone;
    end else if (w_state_nxt == S_PLAY) begin
      w_tone_nxt = song_tone;
    end else begin
      w_tone_nxt = SILENCE;
    end
  end

  assign ibeatNum = r_beat;
  assign en_b     = r_en_b;
  assign pause    = r_pause;
  assign tone     = r_tone;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 SHALL have parameter BEAT_DIV, default 12500000, clk cycles per quarter-beat at tempo 0 (minimum 8).
REQ-002 SHALL have parameter SILENCE, default 32'd20000, the silence tone code.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port play  input  1  start or resume request, one-cycle pulse.
REQ-006 SHALL have port pause_req  input  1  pause request, one-cycle pulse.
REQ-007 SHALL have port stop  input  1  stop request, one-cycle pulse.
REQ-008 SHALL have port tempo  input  2  speed select; the divisor is BEAT_DIV >> tempo.
REQ-009 SHALL have port key_valid  input  1  a piano key is held.
REQ-010 SHALL have port key_tone  input  32  tone of the held key.
REQ-011 SHALL have port song_tone  input  32  tone returned by the song ROM for ibeatNum.
REQ-012 SHALL have port ibeatNum  output  8  beat index to the song ROM.
REQ-013 SHALL have port en_b  output  1  song ROM enable.
REQ-014 SHALL have port pause  output  1  song ROM pause.
REQ-015 SHALL have port tone  output  32  arbitrated tone to the audio divider.
REQ-016 SHALL have port busy  output  1  high in PLAY or PAUSE.
REQ-017 SHALL have port done  output  1  one-cycle pulse at the end of beat 255.

Function
REQ-018 SHALL implement the states IDLE, PLAY, PAUSE and DONE.
REQ-019 SHALL, when several requests are active in one cycle, apply them in priority order stop > play > pause_req.
REQ-020 SHALL make these transitions:
- IDLE --play--> PLAY
- PLAY --pause_req--> PAUSE
- PAUSE --play--> PLAY; pause_req in PAUSE is ignored
- any state --stop--> IDLE
- DONE --play--> PLAY, starting from beat 0
REQ-021 SHALL run a tick counter only in PLAY, counting 0 to (BEAT_DIV>>tempo)-1; at terminal count it clears and ibeatNum increments.
REQ-022 SHALL sample tempo only when the tick counter is 0, so a tempo change never truncates a beat in progress.
REQ-023 SHALL hold both the tick counter and ibeatNum in PAUSE, so resuming continues mid-beat.
REQ-024 SHALL, on stop, clear the tick counter and ibeatNum to 0 in the same edge.
REQ-025 SHALL drive en_b = 1 in PLAY and PAUSE, and pause = 1 only in PAUSE.
REQ-026 SHALL register tone with one-cycle latency, selected as follows:
- key_valid=1: key_tone, in any state
- otherwise, in PLAY: song_tone
- otherwise: SILENCE
REQ-027 SHALL pulse done for exactly one cycle on the edge where beat 255 reaches terminal count.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, force state IDLE, tick=0, ibeatNum=0, tone=SILENCE, en_b=0, pause=0, busy=0, done=0.
REQ-029 SHALL let rst override all requests, including mid-beat and in PAUSE; play is honoured from the first edge after rst falls.

Configuration
REQ-030 SHALL use macro SEQ_LOOP_EN:
- defined: after beat 255, ibeatNum wraps to 0, the state stays PLAY and done still pulses.
- undefined: after beat 255, the state goes to DONE with ibeatNum=0, en_b=0 and tone=SILENCE unless key_valid=1.

Verification (bench uses BEAT_DIV=8)
REQ-031 SHALL cover: rst, then play at tempo 0 -> ibeatNum increments every 8 cycles; busy=1; en_b=1.
REQ-032 SHALL cover: pause_req 3 cycles into beat 5, wait 20 cycles, then play -> ibeatNum holds 5 while paused, pause=1, and beat 6 arrives 5 cycles after resume.
REQ-033 SHALL cover: key_valid=1 with key_tone=262 during PLAY -> tone=262 one cycle later; after key release -> tone=song_tone.
REQ-034 SHALL cover: play, pause_req and stop asserted in the same cycle -> IDLE, ibeatNum=0, tone=20000.
REQ-035 SHALL cover: play through beat 255 -> done pulses 1 cycle; without SEQ_LOOP_EN the state is DONE and busy=0; with it, ibeatNum=0 and the state stays PLAY.
REQ-036 SHALL cover: tempo changed 0->2 mid-beat -> the current beat completes at 8 cycles, and subsequent beats take 2 cycles each.
